// File: rtl/cbus_arb_if.sv
// Control-bus arbitration signals shared by the arbiter and its four masters.
interface cbus_arb_if;
  logic       m0_req;
  logic       m1_req;
  logic       m2_req;
  logic       m3_req;
  logic       m_ack;
  logic       m0_grnt;
  logic       m1_grnt;
  logic       m2_grnt;
  logic       m3_grnt;
  logic [1:0] arb_owner;
  logic       arb_busy;
  logic       arb_timeout;

  modport slave (
    input  m0_req, m1_req, m2_req, m3_req, m_ack,
    output m0_grnt, m1_grnt, m2_grnt, m3_grnt, arb_owner, arb_busy, arb_timeout
  );

  modport master (
    output m0_req, m1_req, m2_req, m3_req, m_ack,
    input  m0_grnt, m1_grnt, m2_grnt, m3_grnt, arb_owner, arb_busy, arb_timeout
  );
endinterface

// File: rtl/cbus_arb.sv
// Four-master round-robin control-bus arbiter with registered one-hot grants.
// Optional grant-hold watchdog enabled by defining CBUS_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant asserted; arbitrate any pending request
// ST_BUSY | grant held by owner until m_ack, abandon or timeout
module cbus_arb #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic       clk,
  input logic       reset_,
  cbus_arb_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] state;
  logic [1:0] owner;
  logic [3:0] req;
  logic [3:0] grnt;
  logic [1:0] winner;
  logic [1:0] rr_cand;
  logic       rr_found;
  logic       owner_req;
  logic       timeout_hit;

  assign req       = {bus.m3_req, bus.m2_req, bus.m1_req, bus.m0_req};
  assign owner_req = req[owner];

  // Search starts one past the last owner so the last owner is lowest priority.
  always_comb begin
    winner   = owner;
    rr_cand  = owner;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = owner + 2'(i);
      if (!rr_found && req[rr_cand]) begin
        winner   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

`ifdef CBUS_ARB_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // hold_cnt counts completed no-ack cycles, so the compare fires on the last held cycle.
  assign timeout_hit = (hold_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == ST_BUSY) && !bus.m_ack && timeout_hit;
      if ((state == ST_BUSY) && !bus.m_ack && owner_req && !timeout_hit)
        hold_cnt <= hold_cnt + CNT_W'(1);
      else
        hold_cnt <= '0;
    end
  end

  assign bus.arb_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign bus.arb_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ST_IDLE;
      owner <= 2'd3;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state <= ST_BUSY;
            owner <= winner;
          end
        end
        ST_BUSY: begin
          if (bus.m_ack) begin
            if (|req) owner <= winner;
            else      state <= ST_IDLE;
          end else if (timeout_hit || !owner_req) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    grnt = 4'b0000;
    if (state == ST_BUSY) grnt[owner] = 1'b1;
  end

  assign bus.m0_grnt   = grnt[0];
  assign bus.m1_grnt   = grnt[1];
  assign bus.m2_grnt   = grnt[2];
  assign bus.m3_grnt   = grnt[3];
  assign bus.arb_owner = owner;
  assign bus.arb_busy  = |grnt;

endmodule

// File: doc/cbus_arb.md
CBUS_ARB -- requirements
Module: cbus_arb

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 255, grant-hold limit in cycles without m_ack (used only when CBUS_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have one clock and an asynchronous active-low reset; `clk` and `reset_` are declared first.
REQ-003 clk  input  1  bus clock; all state changes on rising edge.
REQ-004 reset_  input  1  asynchronous, active-low reset.
REQ-005 m0_req..m3_req  input  1 each  bus request from master 0..3.
REQ-006 m_ack  input  1  slave command acceptance, from the granted master's path.
REQ-007 m0_grnt..m3_grnt  output  1 each  registered one-hot grant; all zero when idle.
REQ-008 arb_owner  output  2  index of current/last owner (encodes UID).
REQ-009 arb_busy  output  1  high while any grant is asserted.
REQ-010 arb_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-011 SHALL implement states IDLE and BUSY; the grant outputs are decoded from registered state only (no combinational path from inputs to grants).
REQ-012 Priority SHALL be round-robin: order arb_owner+1, +2, +3, +0 (mod 4); the last owner has lowest priority.
REQ-013 IDLE: if any m*_req high -> next cycle BUSY, grant the RR winner, arb_owner <= winner; else stay IDLE with all grants 0.
REQ-014 Grant latency from req in IDLE SHALL be exactly 1 cycle.
REQ-015 BUSY, owner req high, m_ack low: SHALL hold the grant unchanged; other requests are ignored (no preemption).
REQ-016 BUSY, m_ack high: if any req high (including owner) -> next cycle grant the RR winner computed from the current owner (back-to-back, no idle cycle); else -> IDLE.
REQ-017 BUSY, owner req low with m_ack low (abandon): -> IDLE next cycle; arb_owner keeps the abandoning index.
REQ-018 m_ack and owner-req-drop in the same cycle SHALL be treated as m_ack (REQ-016).
REQ-019 Requests from non-owners that are asserted and then removed while BUSY SHALL leave no residual effect.
REQ-020 At most one grant SHALL be high in any cycle; arb_busy = OR of the grants.
REQ-021 A master re-granted to itself (sole requester at m_ack) SHALL see its grant stay high continuously.

Reset
REQ-022 When reset_ is low: state IDLE, all grants 0, arb_owner = 2'd3 (master 0 highest priority after reset), arb_busy 0, arb_timeout 0, timeout counter 0.
REQ-023 Reset asserted mid-transaction SHALL drop the grant immediately (asynchronously); no transaction state is retained.

Configuration
REQ-024 Macro CBUS_ARB_TIMEOUT_EN defined: an 8..16-bit counter (width fits TIMEOUT_CYC) clears on every grant change and on m_ack, and increments each BUSY cycle without m_ack; when it reaches TIMEOUT_CYC -> IDLE next cycle, grant dropped, arb_timeout pulses for 1 cycle, arb_owner keeps the revoked index.
REQ-025 Macro CBUS_ARB_TIMEOUT_EN undefined: no counter; arb_timeout is tied 0; the grant is held indefinitely per REQ-015; port list is unchanged.

Verification
REQ-026 After reset, m0_req=m2_req=1 in the same cycle -> next cycle m0_grnt=1, arb_owner=0; on m_ack -> next cycle m2_grnt=1, arb_owner=2.
REQ-027 All four reqs held high, m_ack pulsed every 3rd cycle -> grants rotate 0,1,2,3,0 with no idle cycle between owners.
REQ-028 m1 granted, m3_req toggles while m_ack=0 -> m1_grnt stays 1, m3_grnt stays 0 throughout.
REQ-029 m2 granted, m2_req drops with m_ack=0, no other req -> next cycle all grants 0, arb_busy=0, arb_owner=2.
REQ-030 CBUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, m1 granted, m_ack never high -> grant revoked after exactly 4 held cycles, arb_timeout=1 for one cycle; with m0_req also high, m0 granted the following cycle.
REQ-031 reset_ pulsed low while m3_grnt=1 -> m3_grnt falls without a clock edge; after release, m3_req=m1_req=1 -> m1 granted first (arb_owner reset to 3).
